// File: rtl/vbs_me_pkg.sv
// Shared constants and types for the variable-block-size motion search:
// partition layout of the 41-entry SAD vector and the MV-select state encoding.
package vbs_me_pkg;

    localparam int NUM_PART    = 41;
    localparam int P4X4_BASE   = 0;
    localparam int P4X8_BASE   = 16;
    localparam int P8X4_BASE   = 24;
    localparam int P8X8_BASE   = 32;
    localparam int P16X8_BASE  = 36;
    localparam int P8X16_BASE  = 38;
    localparam int P16X16      = 40;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/vbs_min_cmp.sv
// One partition's running minimum: holds the best SAD and the MV where it
// first occurred; a strictly smaller SAD replaces it, so ties keep the earlier MV.
module vbs_min_cmp #(
    parameter int SAD_WIDTH = 16,
    parameter int MV_WIDTH  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init,
    input  logic                        upd,
    input  logic [SAD_WIDTH-1:0]        sad_in,
    input  logic signed [MV_WIDTH-1:0]  pos_x,
    input  logic signed [MV_WIDTH-1:0]  pos_y,
    output logic [SAD_WIDTH-1:0]        best_sad,
    output logic signed [MV_WIDTH-1:0]  best_mv_x,
    output logic signed [MV_WIDTH-1:0]  best_mv_y
);

    logic [SAD_WIDTH-1:0]       best_sad_d, best_sad_q;
    logic signed [MV_WIDTH-1:0] best_mv_x_d, best_mv_x_q;
    logic signed [MV_WIDTH-1:0] best_mv_y_d, best_mv_y_q;

    always_comb begin
        best_sad_d  = best_sad_q;
        best_mv_x_d = best_mv_x_q;
        best_mv_y_d = best_mv_y_q;
        if (init) begin
            best_sad_d  = '1;
            best_mv_x_d = '0;
            best_mv_y_d = '0;
        end else if (upd && (sad_in < best_sad_q)) begin
            best_sad_d  = sad_in;
            best_mv_x_d = pos_x;
            best_mv_y_d = pos_y;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_sad_q  <= '1;
            best_mv_x_q <= '0;
            best_mv_y_q <= '0;
        end else begin
            best_sad_q  <= best_sad_d;
            best_mv_x_q <= best_mv_x_d;
            best_mv_y_q <= best_mv_y_d;
        end
    end

    assign best_sad  = best_sad_q;
    assign best_mv_x = best_mv_x_q;
    assign best_mv_y = best_mv_y_q;

endmodule

// File: rtl/vbs_mv_select.sv
// Best-MV selector: scans the search window in raster order, one SAD vector per
// accepted beat, and keeps per-partition minima; done pulses once the window is complete.
module vbs_mv_select
    import vbs_me_pkg::*;
#(
    parameter int SAD_WIDTH = 16,
    parameter int SR        = 16,
    parameter int MV_WIDTH  = $clog2(SR) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        sad_valid,
    input  logic [SAD_WIDTH-1:0]        sad_in    [NUM_PART],
    output logic                        busy,
    output logic                        done,
    output logic [SAD_WIDTH-1:0]        best_sad  [NUM_PART],
    output logic signed [MV_WIDTH-1:0]  best_mv_x [NUM_PART],
    output logic signed [MV_WIDTH-1:0]  best_mv_y [NUM_PART],
    output state_t                      dbg_state
);

    localparam logic signed [MV_WIDTH-1:0] POS_MIN = MV_WIDTH'(-SR);
    localparam logic signed [MV_WIDTH-1:0] POS_MAX = MV_WIDTH'(SR - 1);

    // Handshake: a beat is consumed on every rising edge where sad_valid=1 in
    // SEARCH; there is no back-pressure, and sad_valid outside SEARCH is dropped.
    state_t                     state_d, state_q;
    logic signed [MV_WIDTH-1:0] pos_x_d, pos_x_q;
    logic signed [MV_WIDTH-1:0] pos_y_d, pos_y_q;
    logic                       init, upd, last_pos;

    assign init     = (state_q == IDLE) && start;
    assign upd      = (state_q == SEARCH) && sad_valid;
    assign last_pos = (pos_x_q == POS_MAX) && (pos_y_q == POS_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pos_x_q <= POS_MIN;
            pos_y_q <= POS_MIN;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEARCH;
            SEARCH:  if (sad_valid && last_pos) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Raster counter: x runs fastest; wraps are explicit so SR need not be a power of two.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (init) begin
            pos_x_d = POS_MIN;
            pos_y_d = POS_MIN;
        end else if (upd) begin
            if (pos_x_q == POS_MAX) begin
                pos_x_d = POS_MIN;
                pos_y_d = (pos_y_q == POS_MAX) ? POS_MIN : pos_y_q + MV_WIDTH'(1);
            end else begin
                pos_x_d = pos_x_q + MV_WIDTH'(1);
            end
        end
    end

    always_comb begin
        busy      = (state_q == SEARCH);
        done      = (state_q == DONE);
        dbg_state = state_q;
    end

    for (genvar i = 0; i < NUM_PART; i++) begin : g_cell
        vbs_min_cmp #(
            .SAD_WIDTH (SAD_WIDTH),
            .MV_WIDTH  (MV_WIDTH)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .init      (init),
            .upd       (upd),
            .sad_in    (sad_in[i]),
            .pos_x     (pos_x_q),
            .pos_y     (pos_y_q),
            .best_sad  (best_sad[i]),
            .best_mv_x (best_mv_x[i]),
            .best_mv_y (best_mv_y[i])
        );
    end

endmodule

// File: tb/tb_vbs_mv_select.sv
// Directed bench for vbs_mv_select with SR=2 (16 positions, MVs -2..1).
// Inputs change and outputs are sampled on the falling edge.
module tb_vbs_mv_select;
    import vbs_me_pkg::*;

    localparam int SW   = 16;
    localparam int SR   = 2;
    localparam int MW   = 2;
    localparam int NPOS = (2 * SR) * (2 * SR);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 sad_valid;
    logic [SW-1:0]        sad_in    [NUM_PART];
    logic                 busy;
    logic                 done;
    logic [SW-1:0]        best_sad  [NUM_PART];
    logic signed [MW-1:0] best_mv_x [NUM_PART];
    logic signed [MW-1:0] best_mv_y [NUM_PART];
    state_t               dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];
    int exp_sad [NUM_PART];
    int exp_mx  [NUM_PART];
    int exp_my  [NUM_PART];

    vbs_mv_select #(.SAD_WIDTH(SW), .SR(SR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sad_valid (sad_valid),
        .sad_in    (sad_in),
        .busy      (busy),
        .done      (done),
        .best_sad  (best_sad),
        .best_mv_x (best_mv_x),
        .best_mv_y (best_mv_y),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sad_val(input int mode, input int b, input int i);
        case (mode)
            0: return 100;
            1: return (i == 40 && b == 9) ? 7 : 500;
            2: return (b == i % 16) ? 10 + i : 1000 + b * 3 + i;
            default: return 200 + ((b * 7 + i * 3) % 16) * 10;
        endcase
    endfunction

    // driver
    task automatic drive(input bit v, input bit st, input int mode, input int b);
        @(negedge clk);
        sad_valid = v;
        start     = st;
        for (int i = 0; i < NUM_PART; i++)
            sad_in[i] = v ? SW'(sad_val(mode, b, i)) : SW'(16'hDEAD);
    endtask

    // reference model: raster scan, strict-less keeps first minimum
    task automatic model_run(input int mode);
        for (int i = 0; i < NUM_PART; i++) begin
            exp_sad[i] = 32'hFFFF;
            exp_mx[i]  = 0;
            exp_my[i]  = 0;
        end
        for (int b = 0; b < NPOS; b++)
            for (int i = 0; i < NUM_PART; i++)
                if (sad_val(mode, b, i) < exp_sad[i]) begin
                    exp_sad[i] = sad_val(mode, b, i);
                    exp_mx[i]  = -SR + b % (2 * SR);
                    exp_my[i]  = -SR + b / (2 * SR);
                end
    endtask

    // scoreboard
    task automatic check_results(input string tag);
        for (int i = 0; i < NUM_PART; i++) exp_q.push_back(32'(exp_sad[i]));
        for (int i = 0; i < NUM_PART; i++) begin
            check($sformatf("%s_sad[%0d]", tag, i), best_sad[i], exp_q.pop_front());
            check($sformatf("%s_mvx[%0d]", tag, i), best_mv_x[i], exp_mx[i]);
            check($sformatf("%s_mvy[%0d]", tag, i), best_mv_y[i], exp_my[i]);
        end
    endtask

    task automatic run_search(input string tag, input int mode, input bit gaps);
        int d0;
        int g;
        d0 = done_cnt;
        model_run(mode);
        drive(0, 1, mode, 0);
        for (int b = 0; b < NPOS; b++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                if (b == 7 && g == 0) g = 1;
                for (int k = 0; k < g; k++) drive(0, (b == 7 && k == 0), mode, b);
            end
            drive(1, 0, mode, b);
            check($sformatf("%s_busy_b%0d", tag, b), busy, 1);
            check($sformatf("%s_nodone_b%0d", tag, b), done, 0);
        end
        // start held during DONE must be ignored
        drive(0, 1, mode, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_st_done"}, dbg_state, DONE);
        check_results(tag);
        drive(0, 0, mode, 0);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_st_idle"}, dbg_state, IDLE);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        rst = 1'b0;
        start = 1'b0;
        sad_valid = 1'b0;
        for (int i = 0; i < NUM_PART; i++) sad_in[i] = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_sad0", best_sad[0], 32'hFFFF);
        check("rst_sad40", best_sad[40], 32'hFFFF);
        check("rst_mvx40", best_mv_x[40], 0);
        @(negedge clk);
        rst = 1'b1;

        // constant SAD: ties keep (-2,-2)
        run_search("const", 0, 0);
        check("const_sad0_hand", best_sad[0], 100);
        check("const_mvx40_hand", best_mv_x[40], -2);
        check("const_mvy40_hand", best_mv_y[40], -2);

        // single minimum at beat 9 -> (-1,0)
        run_search("single", 1, 0);
        check("single_sad40_hand", best_sad[40], 7);
        check("single_mvx40_hand", best_mv_x[40], -1);
        check("single_mvy40_hand", best_mv_y[40], 0);
        check("single_sad0_hand", best_sad[0], 500);
        check("single_mvx0_hand", best_mv_x[0], -2);

        // distinct minima, partition i at beat i mod 16
        run_search("dist", 2, 0);
        check("dist_mvx5_hand", best_mv_x[5], -1);
        check("dist_mvy5_hand", best_mv_y[5], -1);
        check("dist_mvx40_hand", best_mv_x[40], -2);
        check("dist_mvy40_hand", best_mv_y[40], 0);
        check("dist_mvx15_hand", best_mv_x[15], 1);
        check("dist_mvy15_hand", best_mv_y[15], 1);

        // same stimulus with stalls and a stray start mid-search
        run_search("stall", 2, 1);
        check("stall_sad5_hand", best_sad[5], 15);

        // sad_valid in IDLE is ignored; outputs hold
        drive(1, 0, 0, 0);
        for (int i = 0; i < NUM_PART; i++) sad_in[i] = '0;
        drive(0, 0, 0, 0);
        check("idle_hold_sad5", best_sad[5], 15);
        check("idle_hold_state", dbg_state, IDLE);

        // back-to-back search: no carry-over of the old minima
        run_search("b2b", 3, 0);
        check("b2b_sad0_hand", best_sad[0], 200);
        check("b2b_mvx0_hand", best_mv_x[0], -2);

        // async reset after five beats aborts the search
        d0 = done_cnt;
        drive(0, 1, 0, 0);
        for (int b = 0; b < 5; b++) drive(1, 0, 0, b);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_state", dbg_state, IDLE);
        for (int i = 0; i < NUM_PART; i++) begin
            check($sformatf("abort_sad[%0d]", i), best_sad[i], 32'hFFFF);
            check($sformatf("abort_mvx[%0d]", i), best_mv_x[i], 0);
            check($sformatf("abort_mvy[%0d]", i), best_mv_y[i], 0);
        end
        sad_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) drive(1, 0, 0, k % NPOS);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", dbg_state, IDLE);
        check("abort_hold_sad", best_sad[0], 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
